// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into
// CHUNK-bit slices, one slice resolved per stage, with valid/ready on both sides.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    // Handshake: a beat moves when valid && ready on the same rising edge.
    // The whole pipeline advances unless a held output is not being taken.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opa_d [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] opb_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             cry_q [STAGES];
    logic             cry_d [STAGES];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             advance;
    logic [CHUNK:0]   slice;

    assign advance  = !(vld_q[LAST] && !out_ready);
    assign in_ready = advance;

    always_comb begin
        opa_d[0] = a;
        opb_d[0] = b ^ {WIDTH{sub}};
        vld_d[0] = in_valid;
        slice    = {1'b0, a[CHUNK-1:0]} + {1'b0, opb_d[0][CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, sub};
        sum_d[0] = '0;
        sum_d[0][CHUNK-1:0] = slice[CHUNK-1:0];
        cry_d[0] = slice[CHUNK];
        for (int k = 1; k < STAGES; k++) begin
            opa_d[k] = opa_q[k-1];
            opb_d[k] = opb_q[k-1];
            vld_d[k] = vld_q[k-1];
            slice    = {1'b0, opa_q[k-1][k*CHUNK +: CHUNK]}
                     + {1'b0, opb_q[k-1][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cry_q[k-1]};
            sum_d[k] = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            cry_d[k] = slice[CHUNK];
        end
        ovf_d  = (opa_d[LAST][MSB] == opb_d[LAST][MSB]) &&
                 (sum_d[LAST][MSB] != opa_d[LAST][MSB]);
        zero_d = ~|sum_d[LAST];
        neg_d  = sum_d[LAST][MSB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
                cry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < LAST; k++) begin
                vld_q[k] <= vld_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
                cry_q[k] <= cry_d[k];
            end
            vld_q[LAST] <= vld_d[LAST];
            // Output data holds across bubbles so it only moves with a real beat.
            if (vld_d[LAST]) begin
                opa_q[LAST] <= opa_d[LAST];
                opb_q[LAST] <= opb_d[LAST];
                sum_q[LAST] <= sum_d[LAST];
                cry_q[LAST] <= cry_d[LAST];
                ovf_q       <= ovf_d;
                zero_q      <= zero_d;
                neg_q       <= neg_d;
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign result    = sum_q[LAST];
    assign cout      = cry_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a 16/4 instance and an 8/8 instance, directed spec
// vectors plus random streams checked against an arithmetic reference model.
module tb_addsub_pipe;

    logic clk;
    logic rst_n;

    logic        iv16, ir16, ov16, ordy16, s16, co16, of16, z16, n16;
    logic [15:0] a16, b16, res16;
    logic        iv8, ir8, ov8, ordy8, s8, co8, of8, z8, n8;
    logic [7:0]  a8, b8, res8;

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .sub(s16), .out_valid(ov16), .out_ready(ordy16),
        .result(res16), .cout(co16), .overflow(of16), .zero(z16), .neg(n16)
    );

    addsub_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sub(s8), .out_valid(ov8), .out_ready(ordy8),
        .result(res8), .cout(co8), .overflow(of8), .zero(z8), .neg(n8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {neg, zero, overflow, cout, result[15:0]}
    logic [19:0] exp_q[$];
    logic [19:0] ovr;
    logic        ovr_en;
    int tests_run;
    int fails;
    int cyc_n;
    int acc_cyc;
    int pop_n;
    int last_pop;
    int batch_first;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic logic [19:0] model(input int w, input logic [15:0] aa,
                                          input logic [15:0] bb, input logic s);
        longint full, mask, ua, ub, sa, sb, ur, sr, res;
        logic co, ov;
        full = longint'(1) << w;
        mask = full - 1;
        ua   = longint'(aa) & mask;
        ub   = longint'(bb) & mask;
        sa   = (ua >= full / 2) ? ua - full : ua;
        sb   = (ub >= full / 2) ? ub - full : ub;
        ur   = s ? ua - ub : ua + ub;
        sr   = s ? sa - sb : sa + sb;
        res  = ur & mask;
        co   = s ? (ua >= ub) : (ur >= full);
        ov   = (sr >= full / 2) || (sr < -(full / 2));
        return {res[w-1], res == 0, ov, co, res[15:0]};
    endfunction

    // driver: one clock cycle on the selected instance, checking at negedge
    task automatic cyc(input int sel, input logic v, input logic [15:0] aa,
                       input logic [15:0] bb, input logic s, input logic r);
        logic        ovl, irdy, co, of, z, n;
        logic [15:0] res;
        logic [19:0] e;
        if (sel == 0) begin
            iv16 = v; a16 = aa; b16 = bb; s16 = s; ordy16 = r;
            iv8 = 1'b0; ordy8 = 1'b1;
        end else begin
            iv8 = v; a8 = aa[7:0]; b8 = bb[7:0]; s8 = s; ordy8 = r;
            iv16 = 1'b0; ordy16 = 1'b1;
        end
        @(negedge clk);
        if (sel == 0) begin
            ovl = ov16; irdy = ir16; res = res16; co = co16; of = of16; z = z16; n = n16;
        end else begin
            ovl = ov8; irdy = ir8; res = {8'h00, res8}; co = co8; of = of8; z = z8; n = n8;
        end
        chk("in_ready", irdy, r || !ovl);
        if (ovl) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", ovl, 0);
            end else begin
                e = exp_q[0];
                chk("result", res, e[15:0]);
                chk("cout", co, e[16]);
                chk("overflow", of, e[17]);
                chk("zero", z, e[18]);
                chk("neg", n, e[19]);
                if (r) begin
                    void'(exp_q.pop_front());
                    pop_n++;
                    last_pop = cyc_n;
                    if (batch_first < 0) batch_first = cyc_n;
                end
            end
        end
        if (v && irdy) begin
            exp_q.push_back(ovr_en ? ovr : model(sel == 0 ? 16 : 8, aa, bb, s));
            acc_cyc = cyc_n;
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input logic [15:0] aa, input logic [15:0] bb, input logic s,
                       input logic [15:0] r, input logic c, input logic o,
                       input logic z, input logic n);
        ovr    = {n, z, o, c, r};
        ovr_en = 1'b1;
        cyc(0, 1'b1, aa, bb, s, 1'b1);
        ovr_en = 1'b0;
    endtask

    task automatic drain(input int sel);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cyc(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic lat_test(input int sel, input int stages);
        int p0;
        p0 = pop_n;
        cyc(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 20 && pop_n == p0; i++) cyc(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("latency", last_pop - acc_cyc, stages);
    endtask

    task automatic rand_stream(input int sel, input int n);
        for (int i = 0; i < n; i++)
            cyc(sel, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    endtask

    initial begin
        tests_run = 0; fails = 0; cyc_n = 0; acc_cyc = 0;
        pop_n = 0; last_pop = 0; batch_first = -1; ovr = '0; ovr_en = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0; ordy16 = 1;
        iv8 = 0; a8 = 0; b8 = 0; s8 = 0; ordy8 = 1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid16", ov16, 0);
        chk("rst_result16", res16, 0);
        chk("rst_flags16", {co16, of16, z16, n16}, 0);
        chk("rst_in_ready16", ir16, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_in_ready8", ir8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_test(0, 4);

        // directed vectors, back to back
        dir(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        dir(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        dir(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        dir(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        dir(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        dir(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain(0);

        // 8 back-to-back beats alternating add/sub: 8 results with no gaps
        batch_first = -1;
        begin
            int p0;
            p0 = pop_n;
            for (int i = 0; i < 8; i++) cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'(i % 2), 1'b1);
            drain(0);
            chk("stream_count", pop_n - p0, 8);
            chk("stream_no_gaps", last_pop - batch_first, 7);
        end

        // backpressure: output held 5 cycles while inputs keep being offered
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 5; i++) cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 10; i++) cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        drain(0);

        rand_stream(0, 40);
        drain(0);

        // reset with 3 beats in flight
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        iv16 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov16, 0);
        chk("midrst_result", res16, 0);
        chk("midrst_flags", {co16, of16, z16, n16}, 0);
        chk("midrst_in_ready", ir16, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_test(0, 4);
        drain(0);

        // single-stage instance
        lat_test(1, 1);
        rand_stream(1, 40);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
